// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU: opcode encoding, FSM states and the
// result returned for unassigned opcodes.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_MUL   = 4'd2,
    ALU_DIV   = 4'd3,
    ALU_MOD   = 4'd4,
    ALU_AND   = 4'd5,
    ALU_OR    = 4'd6,
    ALU_XOR   = 4'd7,
    ALU_SHL   = 4'd8,
    ALU_SHR   = 4'd9,
    ALU_RSV10 = 4'd10,
    ALU_RSV11 = 4'd11,
    ALU_RSV12 = 4'd12,
    ALU_RSV13 = 4'd13,
    ALU_RSV14 = 4'd14,
    ALU_RSV15 = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DIV_RUN = 2'd1,
    DONE    = 2'd2
  } alu_state_e;

  localparam logic [31:0] DEFAULT_VAL = 32'h0000_00AC;

endpackage

// File: rtl/alu_multicycle_if.sv
// Operand/result handshake bundle between the issuing controller (master)
// and the ALU (slave).
interface alu_multicycle_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       ALU_Sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] ALU_Out;
  logic             CarryOut;
  logic             Zero;
  logic             DivByZero;

  modport master (
    output in_valid, A, B, ALU_Sel, out_ready,
    input  in_ready, out_valid, ALU_Out, CarryOut, Zero, DivByZero
  );

  modport slave (
    input  in_valid, A, B, ALU_Sel, out_ready,
    output in_ready, out_valid, ALU_Out, CarryOut, Zero, DivByZero
  );
endinterface

// File: rtl/alu_divider.sv
// Restoring unsigned divider, one quotient bit per cycle. quotient/remainder
// present the final step's values during the done cycle so the parent can register them.
module alu_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] dvs_r;
  logic [CNT_W-1:0] cnt_r;
  logic             busy_r;
  logic [WIDTH:0]   trial_s;
  logic [WIDTH:0]   diff_s;
  logic             ge_s;
  logic [WIDTH-1:0] next_rem_s;

  // Trial subtraction for the current quotient bit
  always_comb begin
    trial_s = {rem_r, quo_r[WIDTH-1]};
    diff_s  = trial_s - {1'b0, dvs_r};
    ge_s    = (trial_s >= {1'b0, dvs_r});
    if (ge_s) begin
      next_rem_s = diff_s[WIDTH-1:0];
    end else begin
      next_rem_s = trial_s[WIDTH-1:0];
    end
  end

  // Operand load and iteration state
  always_ff @(posedge clock) begin
    if (reset) begin
      rem_r  <= '0;
      quo_r  <= '0;
      dvs_r  <= '0;
      cnt_r  <= '0;
      busy_r <= 1'b0;
    end else if (start) begin
      rem_r  <= '0;
      quo_r  <= dividend;
      dvs_r  <= divisor;
      cnt_r  <= CNT_W'(WIDTH);
      busy_r <= 1'b1;
    end else if (busy_r) begin
      rem_r  <= next_rem_s;
      quo_r  <= {quo_r[WIDTH-2:0], ge_s};
      cnt_r  <= cnt_r - CNT_W'(1);
      busy_r <= (cnt_r != CNT_W'(1));
    end
  end

  assign busy      = busy_r;
  assign done      = busy_r && (cnt_r == CNT_W'(1));
  assign quotient  = {quo_r[WIDTH-2:0], ge_s};
  assign remainder = next_rem_s;
endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle arithmetic/logic/shift ops plus an iterative
// divider, with valid/ready on operands and a held result until consumed.
module alu_multicycle #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] DEFAULT_VAL = WIDTH'(alu_pkg::DEFAULT_VAL)
) (
  input logic            clock,
  input logic            reset,
  alu_multicycle_if.slave bus
);
  import alu_pkg::*;

  localparam int SH_W = $clog2(WIDTH);

  alu_state_e         state_r;
  alu_op_e            div_op_r;
  logic [WIDTH-1:0]   alu_out_r;
  logic               carry_r;
  logic               zero_r;
  logic               dbz_r;
  logic               out_valid_r;

  alu_op_e            op_s;
  logic [WIDTH-1:0]   res_s;
  logic               carry_s;
  logic [WIDTH:0]     sum_s;
  logic [2*WIDTH-1:0] prod_s;
  logic               is_div_s;
  logic               in_ready_s;
  logic               accept_s;
  logic               div_start_s;
  logic               div_busy_s;
  logic               div_done_s;
  logic [WIDTH-1:0]   quo_s;
  logic [WIDTH-1:0]   rem_s;
  logic [WIDTH-1:0]   div_res_s;

  assign op_s        = alu_op_e'(bus.ALU_Sel);
  assign is_div_s    = (op_s == ALU_DIV) || (op_s == ALU_MOD);
  assign in_ready_s  = !reset && ((state_r == IDLE) || ((state_r == DONE) && bus.out_ready));
  assign accept_s    = bus.in_valid && in_ready_s;
  assign div_start_s = accept_s && is_div_s && (bus.B != '0);
  assign div_res_s   = (div_op_r == ALU_MOD) ? rem_s : quo_s;

  alu_divider #(.WIDTH(WIDTH)) u_div (
    .clock     (clock),
    .reset     (reset),
    .start     (div_start_s),
    .dividend  (bus.A),
    .divisor   (bus.B),
    .busy      (div_busy_s),
    .done      (div_done_s),
    .quotient  (quo_s),
    .remainder (rem_s)
  );

  // Single-cycle datapath; DIV/MOD results here only matter for B == 0
  always_comb begin
    res_s   = '0;
    carry_s = 1'b0;
    sum_s   = {1'b0, bus.A} + {1'b0, bus.B};
    prod_s  = {{WIDTH{1'b0}}, bus.A} * {{WIDTH{1'b0}}, bus.B};
    case (op_s)
      ALU_ADD: begin res_s = sum_s[WIDTH-1:0]; carry_s = sum_s[WIDTH]; end
      ALU_SUB: begin res_s = bus.A - bus.B; carry_s = (bus.A < bus.B); end
      ALU_MUL: begin res_s = prod_s[WIDTH-1:0]; carry_s = |prod_s[2*WIDTH-1:WIDTH]; end
      ALU_DIV: res_s = {WIDTH{1'b1}};
      ALU_MOD: res_s = bus.A;
      ALU_AND: res_s = bus.A & bus.B;
      ALU_OR:  res_s = bus.A | bus.B;
      ALU_XOR: res_s = bus.A ^ bus.B;
      ALU_SHL: res_s = bus.A << bus.B[SH_W-1:0];
      ALU_SHR: res_s = bus.A >> bus.B[SH_W-1:0];
      default: res_s = DEFAULT_VAL;
    endcase
  end

  // Control FSM and registered result/flags
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= IDLE;
      div_op_r    <= ALU_DIV;
      out_valid_r <= 1'b0;
      alu_out_r   <= '0;
      carry_r     <= 1'b0;
      zero_r      <= 1'b0;
      dbz_r       <= 1'b0;
    end else if (accept_s) begin
      div_op_r <= op_s;
      if (div_start_s) begin
        state_r     <= DIV_RUN;
        out_valid_r <= 1'b0;
      end else begin
        state_r     <= DONE;
        out_valid_r <= 1'b1;
        alu_out_r   <= res_s;
        carry_r     <= carry_s;
        zero_r      <= (res_s == '0);
        dbz_r       <= is_div_s;
      end
    end else begin
      case (state_r)
        IDLE: state_r <= IDLE;
        DIV_RUN: begin
          if (div_done_s) begin
            state_r     <= DONE;
            out_valid_r <= 1'b1;
            alu_out_r   <= div_res_s;
            carry_r     <= 1'b0;
            zero_r      <= (div_res_s == '0);
            dbz_r       <= 1'b0;
          end else if (!div_busy_s) begin
            // divider lost its operation: recover rather than hang
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r     <= IDLE;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.ALU_Out   = alu_out_r;
  assign bus.CarryOut  = carry_r;
  assign bus.Zero      = zero_r;
  assign bus.DivByZero = dbz_r;
endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle (WIDTH=8): directed vectors push expected
// results at accept; a monitor pops and compares on every out_valid && out_ready.
module tb_alu_multicycle;

  typedef struct {
    logic [7:0] out;
    logic       c;
    logic       z;
    logic       d;
  } exp_t;

  logic clock;
  logic reset;
  int   checks;
  int   errors;
  exp_t sb_q[$];

  alu_multicycle_if #(.WIDTH(8)) bus ();

  alu_multicycle #(.WIDTH(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  // Offer one op, record its expected result at accept, then measure latency.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel,
                      input logic [7:0] eo, input logic ec, input logic ez, input logic ed,
                      input int lat_exp);
    int n;
    int lat;
    bus.A = a;
    bus.B = b;
    bus.ALU_Sel = sel;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 40) begin
      step();
      n++;
    end
    chk("accept_wait", n < 40, 1);
    sb_q.push_back('{out: eo, c: ec, z: ez, d: ed});
    step();
    bus.in_valid = 1'b0;
    bus.A = ~a;
    bus.B = ~b;
    bus.ALU_Sel = 4'hF;
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      chk("in_ready_busy", bus.in_ready, 0);
      step();
      lat++;
    end
    chk("latency", lat, lat_exp);
  endtask

  // Monitor: compare every consumed result against the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (!reset && bus.out_valid && bus.out_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_result", bus.ALU_Out, 32'hFFFF_FFFF);
        end else begin
          e = sb_q.pop_front();
          chk("ALU_Out", bus.ALU_Out, e.out);
          chk("CarryOut", bus.CarryOut, e.c);
          chk("Zero", bus.Zero, e.z);
          chk("DivByZero", bus.DivByZero, e.d);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.A = 8'h00;
    bus.B = 8'h00;
    bus.ALU_Sel = 4'h0;
    repeat (3) step();
    chk("rst_in_ready_low", bus.in_ready, 0);
    reset = 1'b0;
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_ALU_Out", bus.ALU_Out, 8'h00);
    chk("rst_CarryOut", bus.CarryOut, 0);
    chk("rst_Zero", bus.Zero, 0);
    chk("rst_DivByZero", bus.DivByZero, 0);
    chk("rst_in_ready", bus.in_ready, 1);

    send(8'hB1, 8'h9F, 4'd0,  8'h50, 1'b1, 1'b0, 1'b0, 1);
    send(8'h9D, 8'h60, 4'd0,  8'hFD, 1'b0, 1'b0, 1'b0, 1);
    send(8'h38, 8'h10, 4'd1,  8'h28, 1'b0, 1'b0, 1'b0, 1);
    send(8'h10, 8'h38, 4'd1,  8'hD8, 1'b1, 1'b0, 1'b0, 1);
    send(8'h55, 8'h55, 4'd1,  8'h00, 1'b0, 1'b1, 1'b0, 1);
    send(8'h0E, 8'h0B, 4'd2,  8'h9A, 1'b0, 1'b0, 1'b0, 1);
    send(8'h20, 8'h10, 4'd2,  8'h00, 1'b1, 1'b1, 1'b0, 1);
    send(8'hF4, 8'h2F, 4'd3,  8'h05, 1'b0, 1'b0, 1'b0, 9);
    send(8'hF4, 8'h2F, 4'd4,  8'h09, 1'b0, 1'b0, 1'b0, 9);
    send(8'h13, 8'h00, 4'd3,  8'hFF, 1'b0, 1'b0, 1'b1, 1);
    send(8'h13, 8'h00, 4'd4,  8'h13, 1'b0, 1'b0, 1'b1, 1);
    send(8'hF0, 8'h3C, 4'd5,  8'h30, 1'b0, 1'b0, 1'b0, 1);
    send(8'hF0, 8'h3C, 4'd6,  8'hFC, 1'b0, 1'b0, 1'b0, 1);
    send(8'h81, 8'h0B, 4'd8,  8'h08, 1'b0, 1'b0, 1'b0, 1);
    send(8'h81, 8'h0B, 4'd9,  8'h10, 1'b0, 1'b0, 1'b0, 1);
    send(8'hFF, 8'hFF, 4'hC,  8'hAC, 1'b0, 1'b0, 1'b0, 1);

    // Backpressure: hold an ADD result for 3 cycles, then consume it and
    // accept the next op in the same cycle.
    step();
    bus.out_ready = 1'b0;
    send(8'h05, 8'h03, 4'd0, 8'h08, 1'b0, 1'b0, 1'b0, 1);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step();
      chk("stall_out_valid", bus.out_valid, 1);
      chk("stall_ALU_Out", bus.ALU_Out, 8'h08);
      chk("stall_CarryOut", bus.CarryOut, 0);
      chk("stall_Zero", bus.Zero, 0);
      chk("stall_in_ready", bus.in_ready, 0);
    end
    step();
    bus.out_ready = 1'b1;
    #1;
    chk("b2b_in_ready", bus.in_ready, 1);
    send(8'hF0, 8'h3C, 4'd7, 8'hCC, 1'b0, 1'b0, 1'b0, 1);

    // Reset three cycles into a divide: the result must never appear.
    bus.A = 8'hF4;
    bus.B = 8'h2F;
    bus.ALU_Sel = 4'd3;
    bus.in_valid = 1'b1;
    #1;
    chk("div_abort_ready", bus.in_ready, 1);
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    chk("abort_out_valid", bus.out_valid, 0);
    chk("abort_in_ready_rst", bus.in_ready, 0);
    reset = 1'b0;
    #1;
    chk("abort_in_ready", bus.in_ready, 1);
    for (int i = 0; i < 12; i++) begin
      step();
      chk("abort_no_result", bus.out_valid, 0);
    end

    send(8'h01, 8'hFF, 4'd0, 8'h00, 1'b1, 1'b1, 1'b0, 1);
    repeat (3) step();
    chk("scoreboard_drain", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_multicycle.md
Name: alu_multicycle

Overview:
- Parametrised-width successor of the team's registered 8-bit ALU.
- Adds a valid/ready handshake on input and output, an iterative multi-cycle divider (quotient and remainder), and logic/shift ops.
- Adds Zero and DivByZero flags.
- Sits between an operand-issuing controller and a result consumer; accepts one operation at a time and holds each result until it is consumed.

Parameters:
- WIDTH, 8, operand/result width in bits (>= 4).
- DEFAULT_VAL, 'hAC, result for unassigned opcodes, truncated to WIDTH.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operands/opcode valid.
- in_ready  output  1  block can accept an operation.
- A  input  WIDTH  operand A (unsigned).
- B  input  WIDTH  operand B (unsigned).
- ALU_Sel  input  4  opcode.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer takes result.
- ALU_Out  output  WIDTH  result.
- CarryOut  output  1  carry/borrow/overflow flag.
- Zero  output  1  ALU_Out == 0.
- DivByZero  output  1  DIV/MOD issued with B == 0.

Behaviour:
- Opcodes:
  - 0 ADD: result = A+B; CarryOut = bit WIDTH of the sum.
  - 1 SUB: result = A-B mod 2^WIDTH; CarryOut = borrow (A<B).
  - 2 MUL: result = low WIDTH bits of A*B; CarryOut = |high WIDTH bits.
  - 3 DIV: quotient.
  - 4 MOD: remainder.
  - 5 AND, 6 OR, 7 XOR.
  - 8 SHL: A << B[$clog2(WIDTH)-1:0].
  - 9 SHR: logical right shift by the same amount.
  - 10-15: DEFAULT_VAL.
  - CarryOut = 0 for every op except ADD, SUB, MUL.
- Accept: an operation is accepted on a clock edge where in_valid && in_ready. A, B and ALU_Sel are captured at accept; later input changes are ignored.
- FSM states: IDLE, DIV_RUN, DONE.
  - IDLE, accept of a non-divide op: compute, register result, go to DONE. Latency is 1 cycle (out_valid high the cycle after accept).
  - IDLE, accept of DIV/MOD with B != 0: go to DIV_RUN. Iterative restoring division runs one quotient bit per cycle, WIDTH cycles, then DONE. Latency WIDTH+1.
  - IDLE, accept of DIV/MOD with B == 0: go straight to DONE with ALU_Out = all ones (DIV) or A (MOD), DivByZero = 1, latency 1.
  - DONE: out_valid = 1. ALU_Out and all flags stay stable while out_ready = 0. On out_ready: go to IDLE, or directly accept the next op if in_valid (back-to-back, no bubble).
- in_ready = !reset && (state==IDLE || (state==DONE && out_ready)). in_ready is 0 throughout DIV_RUN.
- Zero and DivByZero are registered with ALU_Out and valid only when out_valid = 1. DivByZero = 0 for all non-divide results.
- Reset:
  - state = IDLE; out_valid, ALU_Out, CarryOut, Zero, DivByZero = 0; divider registers cleared.
  - Reset during DIV_RUN or DONE aborts and discards the operation; no result is ever presented for it.
- in_valid while in_ready = 0 is not consumed; the issuer must hold it.

Decomposition:
- Package alu_pkg holds: enum alu_op_e (the 16 opcode values above), enum alu_state_e {IDLE, DIV_RUN, DONE}, and the default DEFAULT_VAL constant.
- Sub-module alu_divider holds the restoring divider.
  - Parameter: WIDTH.
  - Ports: clock, reset, start, dividend, divisor, busy, done (1-cycle pulse), quotient, remainder.
  - No divide-by-zero handling; the parent never starts it with divisor 0.
- Top level holds the FSM, the single-cycle datapath, output registers and the handshake.

Test Plan:
- WIDTH=8, out_ready=1. ADD A=0xB1 B=0x9F -> ALU_Out=0x50, CarryOut=1, Zero=0, out_valid exactly 1 cycle after accept. Then ADD 0x9D+0x60 -> 0xFD, CarryOut=0.
- SUB A=0x38 B=0x10 -> 0x28, CarryOut=0. SUB A=0x10 B=0x38 -> 0xD8, CarryOut=1.
- MUL 0x0E*0x0B -> 0x9A, CarryOut=0. MUL 0x20*0x10 -> 0x00, CarryOut=1, Zero=1.
- DIV A=0xF4 B=0x2F -> 0x05 with out_valid 9 cycles after accept and in_ready=0 for the 8 DIV_RUN cycles. MOD on the same operands -> 0x09.
- DIV A=0x13 B=0x00 -> ALU_Out=0xFF, DivByZero=1, latency 1. MOD A=0x13 B=0x00 -> 0x13, DivByZero=1. Opcode 0xC -> 0xAC, CarryOut=0.
- Backpressure and reset:
  - ADD result with out_ready=0 for 3 cycles -> ALU_Out and flags unchanged, in_ready=0; consumed on the 4th cycle.
  - Next op offered in that same cycle is accepted back-to-back.
  - reset asserted 3 cycles into a DIV -> out_valid=0 next cycle, in_ready=1 the cycle after reset deasserts, no stale result emitted.
